// File: rtl/iso7816_char_tx.sv
// ISO7816-3 T=0 character transmitter: open-drain start+8 data+parity with error-signal retries.
// Latency: done pulses (12+guardEtus)*clocksPerEtu cycles after acceptance when no error is signalled.
// Backpressure: startTx is accepted only when idle (busy low, no done/txError pulse); otherwise ignored.
module iso7816_char_tx #(
    parameter int DIVIDER_WIDTH = 16,
    parameter int MAX_RETRIES   = 3,
    localparam int RW = (MAX_RETRIES < 4) ? 2 : $clog2(MAX_RETRIES + 1)
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic [DIVIDER_WIDTH-1:0] clocksPerEtu,
    input  logic [7:0]               guardEtus,
    input  logic                     inverseConvention,
    input  logic                     startTx,
    input  logic [7:0]               dataIn,
    input  logic                     ioIn,
    output logic                     ioDriveLow,
    output logic                     busy,
    output logic                     done,
    output logic                     txError,
    output logic [RW-1:0]            retryCount
);

    typedef enum logic [2:0] {IDLE, SEND, CHECK, GUARD, ERRWAIT} state_t;

    localparam logic [DIVIDER_WIDTH-1:0] DIV_ONE = 1;

    state_t                   state;
    logic [DIVIDER_WIDTH-1:0] etu_len;
    logic [DIVIDER_WIDTH-1:0] div_cnt;
    logic [8:0]               etu_cnt;
    logic [7:0]               guard_len;
    logic [9:0]               frame;
    logic [9:0]               frame_next;
    logic                     err_hold;
    logic                     etu_end;
    logic                     accept;
    logic [3:0]               next_bit;
    logic [8:0]               guard_last;

    assign etu_end    = (div_cnt == (etu_len - DIV_ONE));
    assign accept     = (state == IDLE) && startTx && !done && !txError;
    assign next_bit   = etu_cnt[3:0] + 4'd1;
    assign guard_last = 9'd11 + {1'b0, guard_len};

    // frame holds the per-bit "pull low" pattern, so retries replay it unchanged
    always_comb begin
        frame_next    = '0;
        frame_next[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (inverseConvention)
                frame_next[k] = dataIn[8-k];
            else
                frame_next[k] = ~dataIn[k-1];
        end
        frame_next[9] = inverseConvention ? (^dataIn) : ~(^dataIn);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            etu_len    <= '0;
            div_cnt    <= '0;
            etu_cnt    <= '0;
            guard_len  <= '0;
            frame      <= '0;
            err_hold   <= 1'b0;
            ioDriveLow <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            txError    <= 1'b0;
            retryCount <= '0;
        end else begin
            done    <= 1'b0;
            txError <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SEND;
                        etu_len    <= clocksPerEtu;
                        guard_len  <= guardEtus;
                        frame      <= frame_next;
                        div_cnt    <= '0;
                        etu_cnt    <= '0;
                        retryCount <= '0;
                        busy       <= 1'b1;
                        ioDriveLow <= 1'b1;
                    end
                end
                SEND, CHECK, GUARD: begin
                    if (etu_end) begin
                        div_cnt <= '0;
                        if (etu_cnt != 9'h1FF)
                            etu_cnt <= etu_cnt + 9'd1;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                    if (state == SEND && etu_end) begin
                        if (etu_cnt == 9'd9) begin
                            state      <= CHECK;
                            ioDriveLow <= 1'b0;
                        end else begin
                            ioDriveLow <= frame[next_bit];
                        end
                    end
                    if (state == CHECK && etu_cnt == 9'd11 && div_cnt == '0) begin
                        state    <= ioIn ? GUARD : ERRWAIT;
                        err_hold <= 1'b0;
                    end
                    if (state == GUARD && etu_end && etu_cnt == guard_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ERRWAIT: begin
                    if (!err_hold) begin
                        // the cycle the line is first seen high counts as the first of 2 ETUs
                        if (ioIn) begin
                            err_hold <= 1'b1;
                            div_cnt  <= DIV_ONE;
                            etu_cnt  <= '0;
                        end
                    end else if (etu_end) begin
                        div_cnt <= '0;
                        etu_cnt <= etu_cnt + 9'd1;
                        if (etu_cnt == 9'd1) begin
                            if (retryCount < RW'(MAX_RETRIES)) begin
                                retryCount <= retryCount + RW'(1);
                                state      <= SEND;
                                etu_cnt    <= '0;
                                ioDriveLow <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                txError <= 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    ioDriveLow <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iso7816_char_tx.sv
// Directed bench for iso7816_char_tx with an open-drain line model and a scripted receiver.
module tb_iso7816_char_tx;

    logic        clk;
    logic        n_reset;
    logic [15:0] clocks_per_etu;
    logic [7:0]  guard_etus;
    logic        inverse_convention;
    logic        start_tx;
    logic [7:0]  data_in;
    logic        io_in;
    logic        io_drive_low;
    logic        busy;
    logic        done;
    logic        tx_error;
    logic [1:0]  retry_count;
    logic        rx_pull;

    int vectors;
    int miscompares;

    iso7816_char_tx #(.DIVIDER_WIDTH(16), .MAX_RETRIES(3)) dut (
        .clk               (clk),
        .nReset            (n_reset),
        .clocksPerEtu      (clocks_per_etu),
        .guardEtus         (guard_etus),
        .inverseConvention (inverse_convention),
        .startTx           (start_tx),
        .dataIn            (data_in),
        .ioIn              (io_in),
        .ioDriveLow        (io_drive_low),
        .busy              (busy),
        .done              (done),
        .txError           (tx_error),
        .retryCount        (retry_count)
    );

    assign io_in = ~(io_drive_low | rx_pull);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // leaves the bench at t=0, 1ns after the accepting edge
    task automatic kick(input logic [7:0] d, input logic [15:0] e, input logic [7:0] g, input logic inv);
        @(negedge clk);
        data_in            = d;
        clocks_per_etu     = e;
        guard_etus         = g;
        inverse_convention = inv;
        start_tx           = 1'b1;
        @(posedge clk);
        #1;
        start_tx = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (io_drive_low !== 1'b0) begin miscompares++; $display("FAIL reset_drive got %b want 0", io_drive_low); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (tx_error !== 1'b0) begin miscompares++; $display("FAIL reset_txerr got %b want 0", tx_error); end
        vectors++; if (retry_count !== 2'd0) begin miscompares++; $display("FAIL reset_retry got %0d want 0", retry_count); end
        @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_direct();
        logic [9:0] exp_low;
        logic [3:0] k;
        int done_t;
        int done_n;
        exp_low = 10'b0110001001;
        done_t  = -1;
        done_n  = 0;
        kick(8'h3B, 16'd8, 8'd0, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL direct_busy got %b want 1", busy); end
        for (int t = 0; t < 130; t++) begin
            k = 4'(t / 8);
            if (t < 80 && (t % 8 == 0 || t % 8 == 7)) begin
                vectors++;
                if (io_drive_low !== exp_low[k]) begin miscompares++; $display("FAIL direct_bit t=%0d got %b want %b", t, io_drive_low, exp_low[k]); end
            end
            if (t == 80 || t == 95) begin
                vectors++;
                if (io_drive_low !== 1'b0) begin miscompares++; $display("FAIL direct_release t=%0d got %b want 0", t, io_drive_low); end
            end
            if (done === 1'b1) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            step();
        end
        vectors++; if (done_t != 96) begin miscompares++; $display("FAIL direct_done_time got %0d want 96", done_t); end
        vectors++; if (done_n != 1) begin miscompares++; $display("FAIL direct_done_count got %0d want 1", done_n); end
        vectors++; if (retry_count !== 2'd0) begin miscompares++; $display("FAIL direct_retry got %0d want 0", retry_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL direct_busy_after got %b want 0", busy); end
    endtask

    task automatic test_inverse();
        logic [9:0] exp_low;
        logic [3:0] k;
        int done_t;
        exp_low = 10'b0111111001;
        done_t  = -1;
        kick(8'h3F, 16'd8, 8'd0, 1'b1);
        for (int t = 0; t < 120; t++) begin
            k = 4'(t / 8);
            if (t < 80 && t % 8 == 4) begin
                vectors++;
                if (io_drive_low !== exp_low[k]) begin miscompares++; $display("FAIL inverse_bit t=%0d got %b want %b", t, io_drive_low, exp_low[k]); end
            end
            if (done === 1'b1 && done_t < 0) done_t = t;
            step();
        end
        vectors++; if (done_t != 96) begin miscompares++; $display("FAIL inverse_done_time got %0d want 96", done_t); end
    endtask

    task automatic test_nack_once();
        logic [9:0] exp_low;
        logic [3:0] k;
        int done_t;
        int done_n;
        exp_low = 10'b1010110101;
        done_t  = -1;
        done_n  = 0;
        kick(8'hA5, 16'd8, 8'd0, 1'b0);
        for (int t = 0; t < 260; t++) begin
            rx_pull = (t >= 84 && t < 100);
            #0;
            if (t < 80 && t % 8 == 4) begin
                k = 4'(t / 8);
                vectors++;
                if (io_drive_low !== exp_low[k]) begin miscompares++; $display("FAIL nack1_bit0 t=%0d got %b want %b", t, io_drive_low, exp_low[k]); end
            end
            if (t == 100 || t == 115) begin
                vectors++;
                if (io_drive_low !== 1'b0) begin miscompares++; $display("FAIL nack1_hold t=%0d got %b want 0", t, io_drive_low); end
            end
            if (t == 116) begin
                vectors++;
                if (io_drive_low !== 1'b1) begin miscompares++; $display("FAIL nack1_restart got %b want 1", io_drive_low); end
                vectors++;
                if (retry_count !== 2'd1) begin miscompares++; $display("FAIL nack1_retry_mid got %0d want 1", retry_count); end
            end
            if (t >= 116 && t < 196 && (t - 116) % 8 == 4) begin
                k = 4'((t - 116) / 8);
                vectors++;
                if (io_drive_low !== exp_low[k]) begin miscompares++; $display("FAIL nack1_bit1 t=%0d got %b want %b", t, io_drive_low, exp_low[k]); end
            end
            if (done === 1'b1) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            step();
        end
        rx_pull = 1'b0;
        vectors++; if (done_t != 212) begin miscompares++; $display("FAIL nack1_done_time got %0d want 212", done_t); end
        vectors++; if (done_n != 1) begin miscompares++; $display("FAIL nack1_done_count got %0d want 1", done_n); end
        vectors++; if (retry_count !== 2'd1) begin miscompares++; $display("FAIL nack1_retry got %0d want 1", retry_count); end
    endtask

    task automatic test_nack_always();
        int starts;
        int rel;
        int err_t;
        int err_n;
        int done_n;
        logic prev;
        starts = 0;
        rel    = 100;
        err_t  = -1;
        err_n  = 0;
        done_n = 0;
        prev   = 1'b0;
        kick(8'hA5, 16'd8, 8'd0, 1'b0);
        for (int t = 0; t < 620; t++) begin
            rx_pull = (t < 464) && ((t % 116) >= 84) && ((t % 116) < 100);
            #0;
            // a start bit is a pull-low after at least 2 ETUs released
            if (io_drive_low === 1'b1) begin
                if (!prev && rel >= 16) starts++;
                rel = 0;
            end else begin
                rel++;
            end
            prev = io_drive_low;
            if (tx_error === 1'b1) begin
                err_n++;
                if (err_t < 0) err_t = t;
            end
            if (done === 1'b1) done_n++;
            step();
        end
        rx_pull = 1'b0;
        vectors++; if (starts != 4) begin miscompares++; $display("FAIL nackall_attempts got %0d want 4", starts); end
        vectors++; if (err_n != 1) begin miscompares++; $display("FAIL nackall_txerr_count got %0d want 1", err_n); end
        vectors++; if (err_t != 464) begin miscompares++; $display("FAIL nackall_txerr_time got %0d want 464", err_t); end
        vectors++; if (done_n != 0) begin miscompares++; $display("FAIL nackall_done_count got %0d want 0", done_n); end
        vectors++; if (retry_count !== 2'd3) begin miscompares++; $display("FAIL nackall_retry got %0d want 3", retry_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nackall_busy got %b want 0", busy); end
    endtask

    task automatic test_guard_and_ignore();
        logic [9:0] exp_low;
        logic [3:0] k;
        int done_t;
        exp_low = 10'b0110001001;
        done_t  = -1;
        kick(8'h3B, 16'd10, 8'd5, 1'b0);
        for (int t = 0; t < 200; t++) begin
            start_tx = (t == 50);
            if (t == 50) begin
                data_in            = 8'h00;
                inverse_convention = 1'b1;
            end
            if (t < 100 && t % 10 == 5) begin
                k = 4'(t / 10);
                vectors++;
                if (io_drive_low !== exp_low[k]) begin miscompares++; $display("FAIL guard_bit t=%0d got %b want %b", t, io_drive_low, exp_low[k]); end
            end
            if (t == 60) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL guard_busy got %b want 1", busy); end
            end
            if (done === 1'b1 && done_t < 0) done_t = t;
            step();
        end
        start_tx           = 1'b0;
        inverse_convention = 1'b0;
        vectors++; if (done_t != 170) begin miscompares++; $display("FAIL guard_done_time got %0d want 170", done_t); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp_low;
        logic [3:0] k;
        int done_t;
        exp_low = 10'b0110001001;
        done_t  = -1;
        kick(8'h3B, 16'd10, 8'd0, 1'b0);
        repeat (35) step();
        vectors++; if (io_drive_low !== 1'b1) begin miscompares++; $display("FAIL rst_bit3 got %b want 1", io_drive_low); end
        n_reset = 1'b0;
        #1;
        vectors++; if (io_drive_low !== 1'b0) begin miscompares++; $display("FAIL rst_release got %b want 0", io_drive_low); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(posedge clk);
        kick(8'h3B, 16'd8, 8'd0, 1'b0);
        for (int t = 0; t < 110; t++) begin
            if (t < 80 && t % 8 == 3) begin
                k = 4'(t / 8);
                vectors++;
                if (io_drive_low !== exp_low[k]) begin miscompares++; $display("FAIL rst_after_bit t=%0d got %b want %b", t, io_drive_low, exp_low[k]); end
            end
            if (done === 1'b1 && done_t < 0) done_t = t;
            step();
        end
        vectors++; if (done_t != 96) begin miscompares++; $display("FAIL rst_after_done got %0d want 96", done_t); end
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        n_reset            = 1'b0;
        clocks_per_etu     = 16'd8;
        guard_etus         = 8'd0;
        inverse_convention = 1'b0;
        start_tx           = 1'b0;
        data_in            = 8'h00;
        rx_pull            = 1'b0;
        test_reset();
        test_direct();
        test_inverse();
        test_nack_once();
        test_nack_always();
        test_guard_and_ignore();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
